imm_encoder: RTL and testbench
==============================

# imm_encoder

Streaming RISC-V instruction assembler that is the inverse of the core's immediate generator. It takes a base instruction word and a 32-bit signed immediate, range-checks the immediate, scatters it into the I/S/B/J bit positions, and emits the word together with a sequential instruction-memory write address. It sits between the test-program loader and instruction memory. A valid/ready handshake is used on both sides, and unencodable immediates are dropped and counted.

## Interface
Parameters:
- ADDR_W, 32, width of the output write address
- BASE_ADDR, 0, address of the first emitted word
- CNT_W, 16, width of the emitted-word counter

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input word present
- in_ready  out  1  block can accept this cycle
- in_base  in  32  instruction with opcode/rd/rs1/rs2/funct fields set; immediate bit positions ignored
- in_imm  in  32  signed immediate, in byte units for B/J
- in_src  in  2  immediate type: 00 I, 01 S, 10 B, 11 J
- in_last  in  1  marks final instruction of a program
- out_valid  out  1  out_instr/out_addr valid
- out_ready  in  1  downstream accepts
- out_instr  out  32  encoded instruction
- out_addr  out  ADDR_W  byte write address
- out_last  out  1  copy of in_last for this word
- done  out  1  one-cycle pulse after the last word is accepted downstream
- instr_count  out  CNT_W  words accepted downstream; wraps
- err_count  out  8  dropped inputs; saturates at 255
- err_flag  out  1  sticky: at least one drop since reset
- err_clr  in  1  clears err_flag and err_count synchronously

## Operation
- Encoding copies in_base, then overwrites the immediate bits for the selected type:
  - I: [31:20]=imm[11:0]
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0]
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]
- Legality checks (the immediate is illegal if the check fails):
  - I and S: imm[31:11] are all equal.
  - B: imm[31:12] are all equal and imm[0]=0.
  - J: imm[31:20] are all equal and imm[0]=0.
- Required round-trip property: passing a legal encoded word back through the core's immediate generator with the same type reproduces in_imm exactly.
- Accepted input (in_valid & in_ready):
  - Legal: the word loads into the output register and out_valid is set.
  - Illegal: the word is not loaded, err_count increments (saturating), and err_flag is set. The address and instr_count do not advance.
  - An illegal word that carries in_last still produces the done pulse on the next cycle, so program end is never lost.
- Output accepted (out_valid & out_ready):
  - instr_count increments and the address pointer advances by 4, wrapping mod 2^ADDR_W.
  - If out_last=1, done pulses on the next cycle and the address pointer returns to BASE_ADDR. instr_count is not reset.
- err_clr coinciding with a new drop: the clear wins, so err_count=0 and err_flag=0.

## Timing
- Reset values:
  - in_ready=1
  - out_valid=0, out_instr=0, out_addr=BASE_ADDR, out_last=0
  - done=0, instr_count=0, err_count=0, err_flag=0
- Output register:
  - One output register, so latency is 1 cycle from input acceptance to out_valid.
  - in_ready = !out_valid | out_ready (combinational), giving full throughput of one word per cycle under continuous out_ready.
  - While out_valid=1 and out_ready=0, out_instr, out_addr and out_last hold stable.
- out_addr is registered together with out_instr and equals the pointer value at load time.
- Accept and drain in the same cycle: the new word replaces the old one, and the pointer advance for the drained word applies to the new word's out_addr.
- Asynchronous reset mid-transfer immediately returns all outputs to reset values; the pending word is discarded.

## Test plan
- Reset, then ADDI x1,x0,-1: base 0x00000093, imm 0xFFFFFFFF, src 00 -> out_instr 0xFFF00093, out_addr 0x0 one cycle later.
- SW x2,4(x1) then BEQ x0,x0,+8 back-to-back with out_ready=1: base 0x0020A023/imm 4/src 01 -> 0x0020A223 @0x0; base 0x00000063/imm 8/src 10 -> 0x00000463 @0x4. Stream proceeds with no bubble.
- JAL x1,-4 with in_last=1: base 0x000000EF, imm 0xFFFFFFFC, src 11 -> 0xFFDFF0EF. done pulses one cycle after acceptance, and the next word goes to BASE_ADDR.
- Illegal inputs (I imm 0x800, then B imm 3) -> nothing emitted, err_count=2, err_flag=1, address unchanged. Then err_clr -> both clear.
- Hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 and the output stays stable. Releasing out_ready drains one word per cycle, and instr_count matches the number of accepted words.
- Assert rst_n low while out_valid=1 -> outputs go to reset values immediately, and the first word after reset goes to BASE_ADDR.

Source files
------------

// File: rtl/imm_encoder.sv
// Streaming RISC-V instruction assembler: scatters a signed immediate into the
// I/S/B/J fields of a base word and emits it with a sequential write address.
module imm_encoder #(
  parameter int               ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int               CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_base,
  input  logic [31:0]       in_imm,
  input  logic [1:0]        in_src,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              done,
  output logic [CNT_W-1:0]  instr_count,
  output logic [7:0]        err_count,
  output logic              err_flag,
  input  logic              err_clr
);

  localparam logic [1:0] SRC_I = 2'b00;
  localparam logic [1:0] SRC_S = 2'b01;
  localparam logic [1:0] SRC_B = 2'b10;
  localparam logic [1:0] SRC_J = 2'b11;

  function automatic logic [31:0] encode_imm(input logic [31:0] base,
                                             input logic signed [31:0] imm,
                                             input logic [1:0] src);
    logic [31:0] w;
    w = base;
    case (src)
      SRC_I: w[31:20] = imm[11:0];
      SRC_S: begin
        w[31:25] = imm[11:5];
        w[11:7]  = imm[4:0];
      end
      SRC_B: begin
        w[31]    = imm[12];
        w[30:25] = imm[10:5];
        w[11:8]  = imm[4:1];
        w[7]     = imm[11];
      end
      default: begin
        w[31]    = imm[20];
        w[30:21] = imm[10:1];
        w[20]    = imm[11];
        w[19:12] = imm[19:12];
      end
    endcase
    return w;
  endfunction

  // An immediate fits when every bit above the field's sign bit replicates it.
  function automatic logic imm_legal(input logic signed [31:0] imm,
                                     input logic [1:0] src);
    logic ok;
    case (src)
      SRC_I, SRC_S: ok = (&imm[31:11]) | ~(|imm[31:11]);
      SRC_B:        ok = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
      default:      ok = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
    endcase
    return ok;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                  input logic last);
    return last ? BASE_ADDR : a + ADDR_W'(4);
  endfunction

  logic signed [31:0] imm_p0;
  logic [31:0]        enc_p0;
  logic               legal_p0;
  logic               acc_p0;
  logic               load_p0;
  logic               drop_p0;

  logic               vld_p1;
  logic [31:0]        instr_p1;
  logic [ADDR_W-1:0]  addr_p1;
  logic               last_p1;
  logic               drain_p1;

  logic [ADDR_W-1:0]  ptr;
  logic [ADDR_W-1:0]  ptr_nxt;
  logic               done_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [7:0]         err_cnt_r;
  logic               err_flg_r;

  // ---- stage p0: encode and range-check the incoming word ----
  assign imm_p0   = in_imm;
  assign enc_p0   = encode_imm(in_base, imm_p0, in_src);
  assign legal_p0 = imm_legal(imm_p0, in_src);
  assign in_ready = ~vld_p1 | out_ready;
  assign acc_p0   = in_valid & in_ready;
  assign load_p0  = acc_p0 & legal_p0;
  assign drop_p0  = acc_p0 & ~legal_p0;

  // The pointer only advances on downstream acceptance; a word loaded in the
  // same cycle picks up the already-advanced value.
  assign drain_p1 = vld_p1 & out_ready;
  assign ptr_nxt  = drain_p1 ? next_addr(ptr, last_p1) : ptr;

  // ---- stage p1: output register and bookkeeping ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      instr_p1 <= '0;
      addr_p1  <= BASE_ADDR;
      last_p1  <= 1'b0;
      ptr      <= BASE_ADDR;
    end else begin
      ptr <= ptr_nxt;
      if (load_p0) begin
        vld_p1   <= 1'b1;
        instr_p1 <= enc_p0;
        addr_p1  <= ptr_nxt;
        last_p1  <= in_last;
      end else if (drain_p1) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_r    <= 1'b0;
      cnt_r     <= '0;
      err_cnt_r <= '0;
      err_flg_r <= 1'b0;
    end else begin
      done_r <= (drain_p1 & last_p1) | (drop_p0 & in_last);
      if (drain_p1) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
      if (err_clr) begin
        err_cnt_r <= '0;
        err_flg_r <= 1'b0;
      end else if (drop_p0) begin
        err_cnt_r <= sat_inc8(err_cnt_r);
        err_flg_r <= 1'b1;
      end
    end
  end

  assign out_valid   = vld_p1;
  assign out_instr   = instr_p1;
  assign out_addr    = addr_p1;
  assign out_last    = last_p1;
  assign done        = done_r;
  assign instr_count = cnt_r;
  assign err_count   = err_cnt_r;
  assign err_flag    = err_flg_r;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder with a scoreboard model checked every cycle.
module tb_imm_encoder;
  localparam int          ADDR_W = 32;
  localparam int          CNT_W  = 16;
  localparam logic [31:0] BASE   = 32'h0;

  logic              clk, rst_n;
  logic              in_valid, in_ready, in_last, err_clr;
  logic [31:0]       in_base, in_imm;
  logic [1:0]        in_src;
  logic              out_valid, out_ready, out_last, done, err_flag;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic [CNT_W-1:0]  instr_count;
  logic [7:0]        err_count;

  imm_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_base(in_base), .in_imm(in_imm), .in_src(in_src), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .out_last(out_last), .done(done),
    .instr_count(instr_count), .err_count(err_count), .err_flag(err_flag),
    .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference behaviour: immediate ranges as plain integer bounds.
  function automatic logic legal_m(input logic signed [31:0] imm, input logic [1:0] src);
    case (src)
      2'b00, 2'b01: return (imm >= -2048) && (imm <= 2047);
      2'b10:        return (imm >= -4096) && (imm <= 4094) && (imm[0] == 1'b0);
      default:      return (imm >= -1048576) && (imm <= 1048574) && (imm[0] == 1'b0);
    endcase
  endfunction

  function automatic logic [31:0] encode_m(input logic [31:0] b, input logic [31:0] imm,
                                           input logic [1:0] src);
    logic [31:0] w;
    w = b;
    case (src)
      2'b00: w[31:20] = imm[11:0];
      2'b01: begin w[31:25] = imm[11:5]; w[11:7] = imm[4:0]; end
      2'b10: begin w[31] = imm[12]; w[30:25] = imm[10:5]; w[11:8] = imm[4:1]; w[7] = imm[11]; end
      default: begin w[31] = imm[20]; w[30:21] = imm[10:1]; w[20] = imm[11]; w[19:12] = imm[19:12]; end
    endcase
    return w;
  endfunction

  // The core's immediate generator, used to check the round trip on DUT output.
  function automatic logic [31:0] decode_m(input logic [31:0] i, input logic [1:0] src);
    case (src)
      2'b00:   return {{20{i[31]}}, i[31:20]};
      2'b01:   return {{20{i[31]}}, i[31:25], i[11:7]};
      2'b10:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      default: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endcase
  endfunction

  typedef struct {
    logic [31:0] instr;
    logic        last;
    logic [31:0] imm;
    logic [1:0]  src;
  } item_t;

  item_t            q[$];
  logic [31:0]      d_instr[$];
  logic [31:0]      d_addr[$];
  int               d_cyc[$];
  int               done_pulses = 0;
  int               cyc = 0;
  logic [31:0]      exp_addr;
  logic [CNT_W-1:0] exp_cnt;
  int               exp_err;
  logic             exp_flag, exp_done;

  initial begin
    item_t it;
    logic  mv;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        q.delete();
        exp_addr = BASE; exp_cnt = '0; exp_err = 0; exp_flag = 1'b0; exp_done = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_instr", out_instr, 0);
        chk("rst_out_addr", out_addr, BASE);
        chk("rst_done", done, 0);
        chk("rst_instr_count", instr_count, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_in_ready", in_ready, 1);
      end else begin
        mv = (q.size() > 0);
        chk("out_valid", out_valid, mv);
        if (mv) begin
          chk("out_instr", out_instr, q[0].instr);
          chk("out_addr", out_addr, exp_addr);
          chk("out_last", out_last, q[0].last);
          chk("round_trip", decode_m(out_instr, q[0].src), q[0].imm);
        end
        chk("in_ready", in_ready, !mv || out_ready);
        chk("done", done, exp_done);
        if (done) done_pulses++;
        chk("instr_count", instr_count, exp_cnt);
        chk("err_count", err_count, exp_err);
        chk("err_flag", err_flag, exp_flag);
        exp_done = 1'b0;
        if (mv && out_ready) begin
          d_instr.push_back(out_instr);
          d_addr.push_back(out_addr);
          d_cyc.push_back(cyc);
          exp_cnt  = exp_cnt + 1'b1;
          exp_done = q[0].last;
          exp_addr = q[0].last ? BASE : exp_addr + 32'd4;
          void'(q.pop_front());
        end
        if (in_valid && (!mv || out_ready)) begin
          if (legal_m(in_imm, in_src)) begin
            it.instr = encode_m(in_base, in_imm, in_src);
            it.last = in_last; it.imm = in_imm; it.src = in_src;
            q.push_back(it);
          end else begin
            if (exp_err < 255) exp_err++;
            exp_flag = 1'b1;
            if (in_last) exp_done = 1'b1;
          end
        end
        if (err_clr) begin
          exp_err = 0; exp_flag = 1'b0;
        end
      end
    end
  end

  task automatic send(input logic [31:0] b, input logic [31:0] imm, input logic [1:0] s,
                      input logic l);
    in_base = b; in_imm = imm; in_src = s; in_last = l; in_valid = 1'b1;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (in_ready) break;
      if (n > 50) begin
        checks++; errors++;
        $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_drain(input string name, input int idx, input logic [31:0] ei,
                             input logic [31:0] ea);
    if (idx < d_instr.size()) begin
      chk({name, "_instr"}, d_instr[idx], ei);
      chk({name, "_addr"}, d_addr[idx], ea);
    end else begin
      chk({name, "_missing"}, d_instr.size(), idx + 1);
    end
  endtask

  initial begin
    int b, dp, cnt0;
    rst_n = 1'b0; in_valid = 1'b0; in_base = '0; in_imm = '0; in_src = '0;
    in_last = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);

    send(32'h00000093, 32'hFFFFFFFF, 2'b00, 1'b0);
    idle(2);
    check_drain("addi", 0, 32'hFFF00093, 32'h0);

    b = d_instr.size();
    send(32'h0020A023, 32'd4, 2'b01, 1'b0);
    send(32'h00000063, 32'd8, 2'b10, 1'b0);
    idle(2);
    check_drain("sw", b, 32'h0020A223, 32'h4);
    check_drain("beq", b + 1, 32'h00000463, 32'h8);
    if (b + 1 < d_cyc.size()) chk("no_bubble", d_cyc[b + 1] - d_cyc[b], 1);

    b = d_instr.size(); dp = done_pulses;
    send(32'h000000EF, 32'hFFFFFFFC, 2'b11, 1'b1);
    idle(3);
    check_drain("jal", b, 32'hFFDFF0EF, 32'hC);
    chk("jal_done_pulses", done_pulses - dp, 1);
    send(32'h00000093, 32'hFFFFFFFF, 2'b00, 1'b0);
    idle(2);
    check_drain("after_last", b + 1, 32'hFFF00093, BASE);

    b = d_instr.size();
    send(32'h00000013, 32'h00000800, 2'b00, 1'b0);
    send(32'h00000063, 32'h00000003, 2'b10, 1'b0);
    idle(2);
    chk("illegal_err_count", err_count, 2);
    chk("illegal_err_flag", err_flag, 1);
    chk("illegal_no_emit", d_instr.size(), b);
    err_clr = 1'b1; idle(1); err_clr = 1'b0;
    chk("clr_err_count", err_count, 0);
    chk("clr_err_flag", err_flag, 0);

    err_clr = 1'b1;
    send(32'h0000006F, 32'h00000001, 2'b11, 1'b0);
    err_clr = 1'b0;
    idle(1);
    chk("clr_wins_count", err_count, 0);
    chk("clr_wins_flag", err_flag, 0);

    dp = done_pulses;
    send(32'h00000063, 32'h00001000, 2'b10, 1'b1);
    idle(2);
    chk("illegal_last_done", done_pulses - dp, 1);
    send(32'h00000013, 32'h000007FF, 2'b00, 1'b0);
    idle(2);
    check_drain("addr_unchanged", b, 32'h7FF00013, 32'h4);

    for (int i = 0; i < 260; i++) send(32'h00000023, 32'hFFFFF7FF, 2'b01, 1'b0);
    idle(1);
    chk("sat_err_count", err_count, 255);
    chk("sat_err_flag", err_flag, 1);
    err_clr = 1'b1; idle(1); err_clr = 1'b0;

    b = d_instr.size(); cnt0 = instr_count;
    out_ready = 1'b0;
    send(32'h00000013, 32'd5, 2'b00, 1'b0);
    in_base = 32'h00000013; in_imm = 32'd6; in_src = 2'b00; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_out_instr", out_instr, 32'h00500013);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    idle(3);
    check_drain("hold_a", b, 32'h00500013, 32'h8);
    check_drain("hold_b", b + 1, 32'h00600013, 32'hC);
    chk("hold_count", instr_count - cnt0, 2);

    out_ready = 1'b0;
    send(32'h00000013, 32'd9, 2'b00, 1'b0);
    #2;
    chk("pre_reset_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_out_addr", out_addr, BASE);
    chk("async_out_instr", out_instr, 0);
    chk("async_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    b = d_instr.size();
    send(32'h00000093, 32'hFFFFFFFF, 2'b00, 1'b0);
    idle(2);
    check_drain("post_reset", b, 32'hFFF00093, BASE);
    chk("post_reset_count", instr_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end
endmodule
